auth_request_issuer: RTL

Requester-side counterpart of the authentication driver. It arbitrates authentication requests from the PD and DEBUG requesters and encodes the selected request into the 8-bit pending_auth_request word consumed by the driver. It then holds the request until the driver returns a non-zero response message, acknowledges that message, and delivers it to the originating requester. A timeout/retry engine covers the case where the driver never responds.

---
 rtl/auth_request_issuer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/auth_request_issuer.sv
// Requester-side authentication issuer: arbitrates PD/DEBUG requests, drives the
// encoded pending request word, and collects, acknowledges and delivers the driver response.
module auth_request_issuer #(
    parameter int unsigned MSG_LEN        = 256,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned TMR_W          = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pd_req_valid,
    input  logic [1:0]         pd_req_role,
    input  logic [1:0]         pd_req_usb,
    output logic               pd_req_ready,
    input  logic               dbg_req_valid,
    input  logic [1:0]         dbg_req_role,
    input  logic [1:0]         dbg_req_usb,
    output logic               dbg_req_ready,
    output logic [7:0]         pending_auth_request,
    input  logic               drv_resp_valid,
    input  logic [MSG_LEN-1:0] drv_resp_msg,
    output logic               ack_out,
    output logic               pd_resp_valid,
    output logic               dbg_resp_valid,
    input  logic               resp_ready,
    output logic [MSG_LEN-1:0] resp_msg,
    output logic               err_valid,
    output logic [1:0]         err_code,
    output logic               busy
);

    localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [1:0] REQ_PD      = 2'b01;
    localparam logic [1:0] REQ_DBG     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ROLE    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RESP,
        S_RETRY,
        S_ACK,
        S_DELIVER
    } state_e;

    state_e             state_q;
    logic [TMR_W-1:0]   timer_q;
    logic [RTY_W-1:0]   retry_q;
    logic [1:0]         last_grant_q;
    logic [7:0]         word_q;
    logic [7:0]         pending_q;
    logic               pd_ready_q;
    logic               dbg_ready_q;
    logic               ack_q;
    logic               pd_resp_q;
    logic               dbg_resp_q;
    logic [MSG_LEN-1:0] resp_msg_q;
    logic               err_valid_q;
    logic [1:0]         err_code_q;
    logic               busy_q;

    logic       grant_pd_c;
    logic       grant_dbg_c;
    logic [1:0] sel_req_c;
    logic [1:0] sel_role_c;
    logic [1:0] sel_usb_c;
    logic       role_ok_c;
    logic       accept_c;
    logic       resp_hit_c;
    logic       timeout_c;

    // Round-robin arbitration: on a tie, the requester not granted last time wins.
    always_comb begin
        grant_pd_c  = 1'b0;
        grant_dbg_c = 1'b0;
        if (pd_req_valid && dbg_req_valid) begin
            if (last_grant_q == REQ_PD) begin
                grant_dbg_c = 1'b1;
            end else begin
                grant_pd_c = 1'b1;
            end
        end else if (pd_req_valid) begin
            grant_pd_c = 1'b1;
        end else if (dbg_req_valid) begin
            grant_dbg_c = 1'b1;
        end
    end

    // A ready pulse still showing means the requester has not yet dropped valid.
    always_comb begin
        sel_req_c  = grant_pd_c ? REQ_PD : REQ_DBG;
        sel_role_c = grant_pd_c ? pd_req_role : dbg_req_role;
        sel_usb_c  = grant_pd_c ? pd_req_usb : dbg_req_usb;
        role_ok_c  = (sel_role_c == 2'b01) || (sel_role_c == 2'b10);
        accept_c   = (grant_pd_c || grant_dbg_c) && !pd_ready_q && !dbg_ready_q;
        resp_hit_c = drv_resp_valid && (drv_resp_msg != '0);
        timeout_c  = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            retry_q      <= '0;
            last_grant_q <= REQ_DBG;
            word_q       <= '0;
            pending_q    <= '0;
            pd_ready_q   <= 1'b0;
            dbg_ready_q  <= 1'b0;
            ack_q        <= 1'b0;
            pd_resp_q    <= 1'b0;
            dbg_resp_q   <= 1'b0;
            resp_msg_q   <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            pd_ready_q  <= 1'b0;
            dbg_ready_q <= 1'b0;
            ack_q       <= 1'b0;
            err_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        pd_ready_q   <= grant_pd_c;
                        dbg_ready_q  <= grant_dbg_c;
                        last_grant_q <= sel_req_c;
                        if (role_ok_c) begin
                            word_q    <= {sel_req_c, sel_role_c, sel_usb_c, 2'b00};
                            pending_q <= {sel_req_c, sel_role_c, sel_usb_c, 2'b00};
                            timer_q   <= '0;
                            retry_q   <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= S_WAIT_RESP;
                        end else begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_ROLE;
                        end
                    end
                end
                S_WAIT_RESP: begin
                    if (resp_hit_c) begin
                        resp_msg_q <= drv_resp_msg;
                        pending_q  <= '0;
                        ack_q      <= 1'b1;
                        state_q    <= S_ACK;
                    end else if (timeout_c) begin
                        pending_q <= '0;
                        if (retry_q < RTY_W'(MAX_RETRY)) begin
                            state_q <= S_RETRY;
                        end else begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_TIMEOUT;
                            timer_q     <= '0;
                            retry_q     <= '0;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_RETRY: begin
                    retry_q   <= retry_q + RTY_W'(1);
                    timer_q   <= '0;
                    pending_q <= word_q;
                    state_q   <= S_WAIT_RESP;
                end
                S_ACK: begin
                    pd_resp_q  <= (word_q[7:6] == REQ_PD);
                    dbg_resp_q <= (word_q[7:6] == REQ_DBG);
                    state_q    <= S_DELIVER;
                end
                S_DELIVER: begin
                    if (resp_ready) begin
                        pd_resp_q  <= 1'b0;
                        dbg_resp_q <= 1'b0;
                        timer_q    <= '0;
                        retry_q    <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    pending_q <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign pd_req_ready         = pd_ready_q;
    assign dbg_req_ready        = dbg_ready_q;
    assign pending_auth_request = pending_q;
    assign ack_out              = ack_q;
    assign pd_resp_valid        = pd_resp_q;
    assign dbg_resp_valid       = dbg_resp_q;
    assign resp_msg             = resp_msg_q;
    assign err_valid            = err_valid_q;
    assign err_code             = err_code_q;
    assign busy                 = busy_q;

endmodule
